instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//   Byte-serial program loader: the write side of the CPU's byte-addressed instruction memory.
//   Accepts a framed byte stream (length, payload, checksum) over a valid/ready handshake.
//   Writes the payload big-endian into instruction memory starting at the PC reset address.
//   Holds the CPU (CpuHold) until a complete, checksum-verified program is loaded.
// PARAMETERS
//   BASE_ADDR  16'd10  byte address of the first payload byte (matches PC reset value)
//   MEM_BYTES  128     instruction memory size in bytes; the last writable address is MEM_BYTES-1
// PORTS
//   Clock      in   1   system clock; all state updates on the rising edge
//   Reset      in   1   synchronous, active-high reset
//   Start      in   1   begin a load; sampled in IDLE, DONE and ERR only
//   ByteValid  in   1   ByteData holds a valid stream byte
//   ByteData   in   8   stream byte
//   ByteReady  out  1   loader can accept a byte this cycle
//   MemWrite   out  1   instruction memory byte write strobe (one cycle per byte)
//   MemAddr    out  16  instruction memory byte address
//   MemData    out  8   instruction memory byte write data
//   CpuHold    out  1   1 = keep the CPU stalled or reset
//   Done       out  1   program loaded and checksum matched (level)
//   Error      out  1   load aborted (level, sticky)
// BEHAVIOUR
//   Frame: LEN_HI, LEN_LO (N = 16-bit count of instruction words, big-endian), 2N payload bytes, CHK byte.
//   CHK is the XOR of all payload bytes only. The length bytes are excluded. An empty payload gives CHK = 8'h00.
//   A byte is accepted on a rising edge where ByteValid & ByteReady = 1. ByteReady is a registered output.
//   States and transitions:
//     IDLE    -> S_LENH when Start = 1.
//     S_LENH  -> S_LENL on acceptance; stores N[15:8].
//     S_LENL  -> on acceptance, stores N[7:0] and computes END = BASE_ADDR + 2*N (18-bit, no truncation).
//                If END > MEM_BYTES: go to ERR; no payload byte is accepted.
//                Else if N = 0: go to S_CHK.
//                Else: go to S_PAY.
//     S_PAY   -> each accepted byte XORs into the checksum and is written to memory.
//                Moves to S_CHK after byte 2N.
//     S_CHK   -> on acceptance, go to DONE if CHK equals the accumulated XOR, otherwise go to ERR.
//     DONE    -> S_LENH on Start; this clears Done and reasserts CpuHold.
//     ERR     -> S_LENH on Start; this clears Error.
//   Start is ignored in S_LENH, S_LENL, S_PAY and S_CHK.
//   ByteReady = 1 exactly in S_LENH, S_LENL, S_PAY and S_CHK.
//   Memory writes (1-cycle latency):
//     A payload byte accepted at edge k gives MemWrite = 1 during cycle k+1.
//     MemAddr = BASE_ADDR + byte index (index starts at 0); MemData = that byte.
//     Payload bytes are passed through in stream order. The stream carries each instruction high byte first,
//     which is big-endian in memory.
//     MemWrite is never asserted for length or checksum bytes. MemAddr and MemData hold their last values when idle.
//   Outputs per state:
//     CpuHold = 1 in every state except DONE. Done = 1 only in DONE. Error = 1 only in ERR.
//   Reset (takes priority, including mid-load):
//     Next state is IDLE.
//     ByteReady = 0, MemWrite = 0, MemAddr = 16'd0, MemData = 8'd0.
//     CpuHold = 1, Done = 0, Error = 0.
//     The checksum accumulator and byte counter are cleared.
//     Memory already written is not scrubbed.
//   ByteValid with ByteReady = 0 is ignored; no byte is consumed and no write occurs.
//   Gaps in ByteValid stall the loader with no time limit.
// TESTING
//   1. Assert Reset for 2 cycles -> ByteReady = 0, MemWrite = 0, CpuHold = 1, Done = 0, Error = 0; state is IDLE.
//   2. Start, then stream 00 02 90 41 1D 02 CE with ByteValid held high ->
//      writes (10,90) (11,41) (12,1D) (13,02), one cycle each; then Done = 1 and CpuHold = 0.
//   3. Repeat test 2 with ByteValid toggling every other cycle ->
//      the same four writes with no duplicates; Done = 1.
//   4. Repeat test 2 with CHK = 00 -> four writes occur, then Error = 1, CpuHold = 1, Done = 0.
//   5. Length 00 3C (END = 130) -> Error = 1 after LEN_LO, ByteReady drops, no MemWrite.
//      Length 00 3B (END = 128) -> the load is accepted, with the last write at address 127.
//   6. Assert Reset after 3 payload bytes -> IDLE and no further writes.
//      Then Start with 00 00 00 -> Done = 1.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-serial program loader for the CPU instruction memory.
// Takes a framed stream (LEN_HI, LEN_LO, 2N payload bytes, CHK), writes the
// payload starting at BASE_ADDR and holds the CPU until a verified program is in.
//
// Handshake: a byte is consumed on a rising Clock edge where ByteValid and
// ByteReady are both 1. ByteReady is registered and depends only on the loader
// state, never on ByteValid. The producer may drop ByteValid for any number of
// cycles; ByteValid while ByteReady = 0 has no effect.
module instr_mem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'd10,
  parameter int          MEM_BYTES = 128
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        ByteValid,
  input  logic [7:0]  ByteData,
  output logic        ByteReady,
  output logic        MemWrite,
  output logic [15:0] MemAddr,
  output logic [7:0]  MemData,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LENH = 3'd1,
    ST_LENL = 3'd2,
    ST_PAY  = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  // One past the last writable address, widened to match the end-address math.
  localparam logic [17:0] MEM_LIMIT = 18'(MEM_BYTES);

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  csum_q, csum_d;
  logic [16:0] rem_q, rem_d;     // payload bytes still expected
  logic [15:0] ptr_q, ptr_d;     // address of the next payload byte
  logic [7:0]  len_hi_q, len_hi_d;

  logic        accept;
  logic [15:0] len_n;
  logic [17:0] end_addr;

  assign accept   = ByteValid & ready_q;
  assign len_n    = {len_hi_q, ByteData};
  // Full 18-bit end address so oversized lengths cannot wrap into range.
  assign end_addr = {2'b00, BASE_ADDR} + {1'b0, len_n, 1'b0};

  // Next-state, datapath and write-strobe logic.
  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    csum_d   = csum_q;
    rem_d    = rem_q;
    ptr_d    = ptr_q;
    len_hi_d = len_hi_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (Start) begin
          state_d = ST_LENH;
          csum_d  = 8'd0;
          rem_d   = 17'd0;
          ptr_d   = BASE_ADDR;
        end
      end
      ST_LENH: begin
        if (accept) begin
          len_hi_d = ByteData;
          state_d  = ST_LENL;
        end
      end
      ST_LENL: begin
        if (accept) begin
          rem_d = {len_n, 1'b0};
          ptr_d = BASE_ADDR;
          if (end_addr > MEM_LIMIT) begin
            state_d = ST_ERR;
          end else if (len_n == 16'd0) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_PAY;
          end
        end
      end
      ST_PAY: begin
        if (accept) begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          data_d = ByteData;
          ptr_d  = ptr_q + 16'd1;
          csum_d = csum_q ^ ByteData;
          rem_d  = rem_q - 17'd1;
          if (rem_q == 17'd1) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (accept) begin
          state_d = (ByteData == csum_q) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Ready follows the state being entered so it is valid on the first cycle there.
    ready_d = (state_d == ST_LENH) || (state_d == ST_LENL) ||
              (state_d == ST_PAY)  || (state_d == ST_CHK);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 16'd0;
      data_q   <= 8'd0;
      csum_q   <= 8'd0;
      rem_q    <= 17'd0;
      ptr_q    <= 16'd0;
      len_hi_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      csum_q   <= csum_d;
      rem_q    <= rem_d;
      ptr_q    <= ptr_d;
      len_hi_q <= len_hi_d;
    end
  end

  assign ByteReady = ready_q;
  assign MemWrite  = we_q;
  assign MemAddr   = addr_q;
  assign MemData   = data_q;
  assign CpuHold   = (state_q != ST_DONE);
  assign Done      = (state_q == ST_DONE);
  assign Error     = (state_q == ST_ERR);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: frame driver, write scoreboard, status checks.
module tb_instr_mem_loader;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        ByteValid = 1'b0;
  logic [7:0]  ByteData = 8'd0;
  logic        ByteReady;
  logic        MemWrite;
  logic [15:0] MemAddr;
  logic [7:0]  MemData;
  logic        CpuHold;
  logic        Done;
  logic        Error;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int exp_wr   = 0;
  logic [15:0] pay_addr;
  logic [15:0] last_addr = 16'd0;
  logic [31:0] exp_q[$];
  logic [7:0]  frame[$];

  instr_mem_loader #(.BASE_ADDR(16'd10), .MEM_BYTES(128)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .ByteValid(ByteValid),
    .ByteData(ByteData), .ByteReady(ByteReady), .MemWrite(MemWrite),
    .MemAddr(MemAddr), .MemData(MemData), .CpuHold(CpuHold), .Done(Done),
    .Error(Error), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 Clock = ~Clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge Clock) begin
    if (MemWrite === 1'b1) begin
      wr_cnt++;
      last_addr = MemAddr;
      if (exp_q.size() == 0) begin
        check("spurious_write", {8'h00, MemAddr, MemData}, 32'hDEADBEEF);
      end else begin
        check("mem_write", {8'h00, MemAddr, MemData}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic start_load();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    pay_addr = 16'd10;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit is_pay, input bit gap);
    int waited = 0;
    bit acc = 1'b0;
    ByteValid = 1'b1;
    ByteData  = b;
    while (!acc && waited < 50) begin
      acc = ByteReady;
      tick();
      waited++;
    end
    ByteValid = 1'b0;
    if (!acc) begin
      check("accept_timeout", {31'd0, acc}, 32'd1);
    end else if (is_pay) begin
      exp_q.push_back({8'h00, pay_addr, b});
      exp_wr++;
      pay_addr++;
    end
    if (gap) tick();
  endtask

  task automatic send_frame(input bit gap);
    for (int i = 0; i < frame.size(); i++) begin
      send_byte(frame[i], (i >= 2) && (i < frame.size() - 1), gap);
    end
  endtask

  task automatic wait_end();
    int w = 0;
    while (!(Done === 1'b1 || Error === 1'b1) && w < 50) begin
      tick();
      w++;
    end
  endtask

  // Holds ByteValid with junk while the loader is not ready; must not write.
  task automatic idle_valid(input int cycles);
    ByteValid = 1'b1;
    ByteData  = 8'h55;
    repeat (cycles) tick();
    ByteValid = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h);
    check({tag, "_done"}, {31'd0, Done}, {31'd0, d});
    check({tag, "_error"}, {31'd0, Error}, {31'd0, e});
    check({tag, "_cpuhold"}, {31'd0, CpuHold}, {31'd0, h});
    check({tag, "_ready"}, {31'd0, ByteReady}, 32'd0);
  endtask

  initial begin
    logic [7:0] chk;
    logic [7:0] r;

    // Test 1: reset state.
    Reset = 1'b1;
    tick();
    tick();
    check("rst_ready", {31'd0, ByteReady}, 32'd0);
    check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("rst_cpuhold", {31'd0, CpuHold}, 32'd1);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_error", {31'd0, Error}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    check("rst_memaddr", {16'd0, MemAddr}, 32'd0);
    check("rst_memdata", {24'd0, MemData}, 32'd0);
    Reset = 1'b0;
    tick();
    check("idle_ready", {31'd0, ByteReady}, 32'd0);

    // Test 2: good frame, ByteValid held high.
    start_load();
    check("lenh_ready", {31'd0, ByteReady}, 32'd1);
    frame = '{8'h00, 8'h02, 8'h90, 8'h41, 8'h1D, 8'h02, 8'hCE};
    send_frame(1'b0);
    wait_end();
    check_status("t2", 1'b1, 1'b0, 1'b0);
    idle_valid(4);
    check("t2_writes", wr_cnt, exp_wr);

    // Test 3: same frame with ByteValid toggling.
    start_load();
    check("t3_restart_done", {31'd0, Done}, 32'd0);
    check("t3_restart_hold", {31'd0, CpuHold}, 32'd1);
    send_frame(1'b1);
    wait_end();
    check_status("t3", 1'b1, 1'b0, 1'b0);
    check("t3_writes", wr_cnt, exp_wr);

    // Test 4: bad checksum.
    start_load();
    frame = '{8'h00, 8'h02, 8'h90, 8'h41, 8'h1D, 8'h02, 8'h00};
    send_frame(1'b0);
    wait_end();
    check_status("t4", 1'b0, 1'b1, 1'b1);
    check("t4_writes", wr_cnt, exp_wr);

    // Test 5a: END = 130 overflows memory, no payload accepted.
    start_load();
    check("t5_error_cleared", {31'd0, Error}, 32'd0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    check_status("t5a", 1'b0, 1'b1, 1'b1);
    check("t5a_state", {29'd0, dbg_state}, 32'd6);
    idle_valid(4);
    check("t5a_writes", wr_cnt, exp_wr);

    // Test 5b: END = 128 exactly fills memory, random payload.
    start_load();
    frame = '{8'h00, 8'h3B};
    chk = 8'h00;
    for (int i = 0; i < 118; i++) begin
      r = 8'($urandom_range(0, 255));
      frame.push_back(r);
      chk = chk ^ r;
    end
    frame.push_back(chk);
    send_frame(1'b0);
    wait_end();
    check_status("t5b", 1'b1, 1'b0, 1'b0);
    check("t5b_last_addr", {16'd0, last_addr}, 32'd127);
    check("t5b_writes", wr_cnt, exp_wr);

    // Test 6: reset mid-load, then an empty program.
    start_load();
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'hA1, 1'b1, 1'b0);
    send_byte(8'hB2, 1'b1, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("t6_state", {29'd0, dbg_state}, 32'd0);
    check("t6_ready", {31'd0, ByteReady}, 32'd0);
    check("t6_memaddr", {16'd0, MemAddr}, 32'd0);
    check("t6_memdata", {24'd0, MemData}, 32'd0);
    check("t6_cpuhold", {31'd0, CpuHold}, 32'd1);
    idle_valid(4);
    check("t6_writes", wr_cnt, exp_wr);
    start_load();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    wait_end();
    check_status("t6_empty", 1'b1, 1'b0, 1'b0);

    tick();
    check("final_writes", wr_cnt, exp_wr);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
